sid_audio_i2s: RTL and testbench
================================

SID_AUDIO_I2S -- requirements
Module: sid_audio_i2s

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 8: clk cycles per BCLK half-period, legal range 2..255.
REQ-002 SHALL have parameter AVG_LOG2, default 2: log2 of the number of input samples averaged per output sample, legal range 0..4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all state.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port audio_in, input, 16 bits: two's-complement sample from the SID filter output.
REQ-006 SHALL have port audio_valid, input, 1 bit: single-cycle qualifier for audio_in (driven by ce_1m).
REQ-007 SHALL have port i2s_bclk, output, 1 bit: I2S bit clock.
REQ-008 SHALL have port i2s_lrclk, output, 1 bit: I2S word select; 0 = left channel.
REQ-009 SHALL have port i2s_data, output, 1 bit: I2S serial data, MSB first.
REQ-010 SHALL have port frame_strobe, output, 1 bit: one-clk pulse each time a new frame sample is latched.
REQ-011 SHALL have port sample_out, output, 16 bits: the sample being transmitted in the current frame.

Function
REQ-012 SHALL run a divider counting 0..BCLK_HALF-1 and toggle i2s_bclk on the terminal count, so the BCLK period is 2*BCLK_HALF clk cycles.
REQ-013 SHALL keep a 6-bit slot counter (0..63) that advances on every BCLK falling toggle and wraps 63->0.
REQ-014 SHALL drive i2s_lrclk = slot[5]; i2s_lrclk and i2s_data SHALL change only on BCLK falling toggles.
REQ-015 SHALL encode each channel in I2S format: channel slot 0 = 0, slots 1..16 = sample bits 15..0, slots 17..31 = 0.
REQ-016 SHALL transmit the same sample_out value on the left and right channels (mono).
REQ-017 SHALL, on the 63->0 slot wrap, copy the holding register into sample_out and pulse frame_strobe for exactly one clk.
REQ-018 SHALL, with averaging enabled, sign-extend audio_in into a (16+AVG_LOG2)-bit accumulator on each audio_valid.
REQ-019 SHALL, after 2^AVG_LOG2 valid inputs, load the holding register with the accumulator arithmetically shifted right by AVG_LOG2 (floor), then clear the accumulator and the input count.
REQ-020 SHALL include the completing sample in the sum when audio_valid coincides with block completion; the next block SHALL start empty.
REQ-021 SHALL, when the holding-register load and the frame latch occur in the same clk, latch the pre-update holding value; the new value SHALL appear in the next frame.
REQ-022 SHALL, when several averaged blocks complete within one frame, overwrite the holding register each time; only the latest block is transmitted, silently.
REQ-023 SHALL have latency from holding-register update to first serialized MSB of at most one frame plus 2 BCLK periods.

Reset
REQ-024 SHALL, while reset_n is low (asynchronous assert), clear: i2s_bclk, i2s_lrclk, i2s_data, frame_strobe, sample_out, the holding register, the accumulator, the input count, the divider and the slot counter.
REQ-025 SHALL abort any frame in progress when reset asserts; there is no partial-frame recovery.
REQ-026 SHALL, after reset deasserts, toggle i2s_bclk high first, BCLK_HALF clk cycles later, and transmit zero samples until the first latch.

Configuration
REQ-027 SHALL compile averaging (REQ-018..REQ-020) in only when SID_AUDIO_AVG_EN is defined.
REQ-028 SHALL, without SID_AUDIO_AVG_EN, load the holding register directly with audio_in on every audio_valid; AVG_LOG2 is then ignored and no accumulator is built.

Structure
REQ-029 SHALL place the shared constants (slot count 64, channel width 32, data width 16) and a slot-counter typedef in package sid_audio_pkg.
REQ-030 SHALL place the divider, BCLK and slot counter in one sub-module, sid_i2s_clkgen, which outputs the bclk level, a falling-toggle pulse and the slot count.

Verification
REQ-031 SHALL check reset: hold reset_n low at 10 clks -> all outputs 0; release -> i2s_bclk rises after exactly 8 clks and the first frame is all-zero.
REQ-032 SHALL check constant input: AVG on, audio_in=16'h1234 with valid every 16 clks -> from the second frame, both channels carry 0x1234 in slots 1..16 and 0 elsewhere.
REQ-033 SHALL check averaging: inputs 100, 200, 300, 400 -> holding = 250; inputs -4, -4, -4, -8 -> holding = -5 (16'hFFFB).
REQ-034 SHALL check the macro off: valids carrying 5 then 7 within one frame -> next frame transmits 7.
REQ-035 SHALL check coincidence: block completion on the same clk as the slot 63->0 wrap -> the current frame keeps the old value and the following frame carries the new one.
REQ-036 SHALL check reset mid-frame: assert reset_n at slot 20 -> bclk, lrclk and data go 0 immediately without waiting for clk, and the accumulator is cleared.

Source files
------------

// File: rtl/sid_audio_pkg.sv
// sid_audio_pkg: frame geometry, slot/sample types and the I2S bit-select helper
// shared by the SID audio I2S transmitter and its bit-clock generator.
package sid_audio_pkg;

  localparam int SLOT_COUNT = 64;   // BCLK slots per stereo frame
  localparam int CHAN_WIDTH = 32;   // slots per channel
  localparam int DATA_WIDTH = 16;   // sample width

  typedef logic [$clog2(SLOT_COUNT)-1:0] slot_t;
  typedef logic [DATA_WIDTH-1:0]         sample_t;

  // Wire bit for a slot: channel slot 0 is the I2S one-bit delay, slots 1..16
  // carry the sample MSB first, the remainder of the channel is zero padding.
  function automatic logic i2s_bit(input sample_t sample, input slot_t slot);
    logic [$clog2(CHAN_WIDTH)-1:0] ch;
    logic [$clog2(DATA_WIDTH)-1:0] idx;
    ch  = slot[$clog2(CHAN_WIDTH)-1:0];
    idx = '0;
    if (ch >= 5'd1 && ch <= 5'(DATA_WIDTH)) begin
      idx = 4'(5'(DATA_WIDTH) - ch);
      return sample[idx];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/sid_i2s_clkgen.sv
// sid_i2s_clkgen: BCLK half-period divider, BCLK level and 64-slot counter.
// bclk_fall is a one-clk pulse on the clk edge where BCLK toggles low; the
// slot counter advances on that same edge.
module sid_i2s_clkgen
  import sid_audio_pkg::*;
#(
  parameter int BCLK_HALF = 8
) (
  input  logic  clk,
  input  logic  reset_n,
  output logic  bclk,
  output logic  bclk_fall,
  output slot_t slot
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

  logic [7:0] div_reg;
  logic       div_tc;
  logic       bclk_reg;
  slot_t      slot_reg;

  assign div_tc    = (div_reg == DIV_LAST);
  assign bclk_fall = div_tc && bclk_reg;
  assign bclk      = bclk_reg;
  assign slot      = slot_reg;

  // Half-period divider, restarting at each terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    div_reg <= '0;
    else if (div_tc) div_reg <= '0;
    else             div_reg <= div_reg + 8'd1;
  end

  // BCLK toggles on terminal count; coming out of reset the first toggle is a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    bclk_reg <= 1'b0;
    else if (div_tc) bclk_reg <= ~bclk_reg;
  end

  // Slot counter steps on falling toggles; the 6-bit width gives the 63->0 wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       slot_reg <= '0;
    else if (bclk_fall) slot_reg <= slot_reg + slot_t'(1);
  end

endmodule

// File: rtl/sid_audio_i2s.sv
// sid_audio_i2s: mono SID audio to I2S transmitter. Input samples land in a
// holding register that is copied to sample_out at every frame wrap and sent
// on both channels, MSB first, one bit delayed from LRCLK.
// Optional feature macro SID_AUDIO_AVG_EN: when defined, 2^AVG_LOG2 input
// samples are averaged (floor) per holding-register update; otherwise every
// valid input loads the holding register directly.
module sid_audio_i2s
  import sid_audio_pkg::*;
#(
  parameter int BCLK_HALF = 8,
  parameter int AVG_LOG2  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] audio_in,
  input  logic                  audio_valid,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_data,
  output logic                  frame_strobe,
  output logic [DATA_WIDTH-1:0] sample_out
);

  // Reject out-of-range configurations at elaboration.
  if (BCLK_HALF < 2 || BCLK_HALF > 255) begin : g_bad_bclk_half
    $error("sid_audio_i2s: BCLK_HALF must be 2..255");
  end
  if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg_log2
    $error("sid_audio_i2s: AVG_LOG2 must be 0..4");
  end

  logic    bclk_fall;
  slot_t   slot;
  slot_t   slot_next;
  sample_t hold_reg;
  sample_t sample_reg;
  logic    lrclk_reg;
  logic    data_reg;
  logic    strobe_reg;

  sid_i2s_clkgen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .bclk      (i2s_bclk),
    .bclk_fall (bclk_fall),
    .slot      (slot)
  );

  assign slot_next    = slot + slot_t'(1);
  assign i2s_lrclk    = lrclk_reg;
  assign i2s_data     = data_reg;
  assign frame_strobe = strobe_reg;
  assign sample_out   = sample_reg;

`ifdef SID_AUDIO_AVG_EN
  localparam int                ACC_W    = DATA_WIDTH + AVG_LOG2;
  localparam logic [AVG_LOG2:0] CNT_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_avg;
  logic [AVG_LOG2:0]       cnt_reg;

  // The completing sample is part of the sum, so the average uses acc_sum.
  assign acc_sum = acc_reg + ACC_W'($signed(audio_in));
  assign acc_avg = acc_sum >>> AVG_LOG2;

  // Accumulate a block of inputs; on the last one publish the floor average and restart empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      hold_reg <= '0;
    end else if (audio_valid) begin
      if (cnt_reg == CNT_LAST) begin
        hold_reg <= acc_avg[DATA_WIDTH-1:0];
        acc_reg  <= '0;
        cnt_reg  <= '0;
      end else begin
        acc_reg  <= acc_sum;
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end
`else
  // Without averaging every valid input overwrites the holding register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         hold_reg <= '0;
    else if (audio_valid) hold_reg <= audio_in;
  end
`endif

  // Serializer: LRCLK/data move only on BCLK falls; the 63->0 wrap latches the
  // holding register (pre-update value if it is written on the same clk).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrclk_reg  <= 1'b0;
      data_reg   <= 1'b0;
      strobe_reg <= 1'b0;
      sample_reg <= '0;
    end else begin
      strobe_reg <= 1'b0;
      if (bclk_fall) begin
        lrclk_reg <= slot_next[$bits(slot_t)-1];
        data_reg  <= i2s_bit(sample_reg, slot_next);
        if (slot == slot_t'(SLOT_COUNT - 1)) begin
          sample_reg <= hold_reg;
          strobe_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sid_audio_i2s.sv
// tb_sid_audio_i2s: directed bench for sid_audio_i2s (BCLK_HALF=8, AVG_LOG2=2).
// A receiver samples i2s_data/i2s_lrclk on each BCLK rise and assembles 64-slot
// frames; tests drive audio_valid at absolute clk counts after reset release.
// With BCLK_HALF=8: BCLK rises at edge 8, slot s falls in at edge 16*s, the
// 63->0 wrap of frame k happens at edge 1024*(k+1) and frame k is fully
// received at edge 1024*k+1016.
module tb_sid_audio_i2s;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] audio_in = '0;
  logic        audio_valid = 1'b0;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_data;
  logic        frame_strobe;
  logic [15:0] sample_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

  sid_audio_i2s #(
    .BCLK_HALF (8),
    .AVG_LOG2  (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .audio_in     (audio_in),
    .audio_valid  (audio_valid),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_data     (i2s_data),
    .frame_strobe (frame_strobe),
    .sample_out   (sample_out)
  );

  always #5 clk = ~clk;

  // clk edges since reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // I2S receiver
  logic [63:0] rx_data_sr = '0;
  logic [63:0] rx_lr_sr = '0;
  logic [63:0] last_data = '0;
  logic [63:0] last_lr = '0;
  logic        rx_prev_bclk = 1'b0;
  int          rx_idx = 0;
  int          frames_rx = 0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_prev_bclk <= 1'b0;
      rx_idx       <= 0;
    end else begin
      rx_prev_bclk <= i2s_bclk;
      if (!rx_prev_bclk && i2s_bclk) begin
        rx_data_sr[rx_idx] <= i2s_data;
        rx_lr_sr[rx_idx]   <= i2s_lrclk;
        if (rx_idx == 63) begin
          last_data <= {i2s_data, rx_data_sr[62:0]};
          last_lr   <= {i2s_lrclk, rx_lr_sr[62:0]};
          frames_rx <= frames_rx + 1;
          rx_idx    <= 0;
        end else begin
          rx_idx <= rx_idx + 1;
        end
      end
    end
  end

  function automatic logic [63:0] exp_frame(input logic [15:0] s);
    logic [63:0] f;
    int ch;
    f = '0;
    for (int i = 0; i < 64; i++) begin
      ch = i % 32;
      if (ch >= 1 && ch <= 16) f[i] = s[16 - ch];
    end
    return f;
  endfunction

  task automatic go_to(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Present one valid input so that it is sampled on edge e.
  task automatic valid_at(input int e, input logic [15:0] v);
    go_to(e - 1);
    audio_in    = v;
    audio_valid = 1'b1;
    @(negedge clk);
    audio_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int rise_at;
    int f0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b expected 0", i2s_bclk); end
    checks++; if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL reset_lrclk: got %b expected 0", i2s_lrclk); end
    checks++; if (i2s_data !== 1'b0) begin errors++; $display("FAIL reset_data: got %b expected 0", i2s_data); end
    checks++; if (frame_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", frame_strobe); end
    checks++; if (sample_out !== 16'h0000) begin errors++; $display("FAIL reset_sample: got %h expected 0000", sample_out); end
    f0 = frames_rx;
    reset_n = 1'b1;
    rise_at = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (i2s_bclk === 1'b1) begin
        rise_at = e;
        break;
      end
    end
    checks++; if (rise_at != 8) begin errors++; $display("FAIL bclk_first_rise: got %0d clks expected 8", rise_at); end
    go_to(1017);
    checks++; if (frames_rx - f0 != 1) begin errors++; $display("FAIL first_frame_count: got %0d expected 1", frames_rx - f0); end
    checks++; if (last_data !== 64'h0) begin errors++; $display("FAIL first_frame_data: got %h expected %h", last_data, 64'h0); end
    checks++; if (last_lr !== LR_EXP) begin errors++; $display("FAIL first_frame_lrclk: got %h expected %h", last_lr, LR_EXP); end
    $display("test_reset: checks %0d", checks);
  endtask

  task automatic test_const();
    int f0;
    do_reset();
    f0 = frames_rx;
    for (int e = 16; e <= 2032; e += 16) begin
      valid_at(e, 16'h1234);
      if (e == 1024) begin
        checks++; if (last_data !== 64'h0) begin errors++; $display("FAIL const_frame0: got %h expected %h", last_data, 64'h0); end
        checks++; if (sample_out !== 16'h1234) begin errors++; $display("FAIL const_latch: got %h expected 1234", sample_out); end
        checks++; if (frame_strobe !== 1'b1) begin errors++; $display("FAIL const_strobe: got %b expected 1", frame_strobe); end
      end
    end
    go_to(2041);
    checks++; if (frames_rx - f0 != 2) begin errors++; $display("FAIL const_frame_count: got %0d expected 2", frames_rx - f0); end
    checks++; if (last_data !== exp_frame(16'h1234)) begin errors++; $display("FAIL const_frame1: got %h expected %h", last_data, exp_frame(16'h1234)); end
    checks++; if (last_lr !== LR_EXP) begin errors++; $display("FAIL const_lrclk: got %h expected %h", last_lr, LR_EXP); end
    $display("test_const: checks %0d", checks);
  endtask

  task automatic test_last_wins();
    do_reset();
    for (int i = 0; i < 4; i++) valid_at(200 + 16 * i, 16'd5);
    for (int i = 0; i < 4; i++) valid_at(400 + 16 * i, 16'd7);
    go_to(1024);
    checks++; if (sample_out !== 16'd7) begin errors++; $display("FAIL last_wins_latch: got %h expected 0007", sample_out); end
    go_to(2041);
    checks++; if (last_data !== exp_frame(16'd7)) begin errors++; $display("FAIL last_wins_frame: got %h expected %h", last_data, exp_frame(16'd7)); end
    $display("test_last_wins: checks %0d", checks);
  endtask

`ifdef SID_AUDIO_AVG_EN
  task automatic test_avg();
    do_reset();
    valid_at(100, 16'd100);
    valid_at(116, 16'd200);
    valid_at(132, 16'd300);
    valid_at(148, 16'd400);
    go_to(1024);
    checks++; if (sample_out !== 16'd250) begin errors++; $display("FAIL avg_pos: got %h expected 00fa", sample_out); end
    valid_at(1100, 16'hFFFC);
    valid_at(1116, 16'hFFFC);
    valid_at(1132, 16'hFFFC);
    valid_at(1148, 16'hFFF8);
    go_to(2041);
    checks++; if (last_data !== exp_frame(16'd250)) begin errors++; $display("FAIL avg_pos_frame: got %h expected %h", last_data, exp_frame(16'd250)); end
    go_to(2048);
    checks++; if (sample_out !== 16'hFFFB) begin errors++; $display("FAIL avg_neg: got %h expected fffb", sample_out); end
    valid_at(2100, 16'h0100);
    valid_at(2116, 16'h0100);
    valid_at(2132, 16'h0100);
    go_to(3065);
    checks++; if (last_data !== exp_frame(16'hFFFB)) begin errors++; $display("FAIL avg_neg_frame: got %h expected %h", last_data, exp_frame(16'hFFFB)); end
    go_to(3072);
    checks++; if (sample_out !== 16'hFFFB) begin errors++; $display("FAIL avg_partial_block: got %h expected fffb", sample_out); end
    $display("test_avg: checks %0d", checks);
  endtask
`else
  task automatic test_direct();
    do_reset();
    valid_at(100, 16'd100);
    valid_at(116, 16'd200);
    valid_at(132, 16'd300);
    valid_at(148, 16'd400);
    go_to(1024);
    checks++; if (sample_out !== 16'd400) begin errors++; $display("FAIL direct_load: got %h expected 0190", sample_out); end
    $display("test_direct: checks %0d", checks);
  endtask
`endif

  task automatic test_coincide();
    do_reset();
    for (int i = 0; i < 4; i++) valid_at(100 + 16 * i, 16'h1111);
`ifdef SID_AUDIO_AVG_EN
    valid_at(976, 16'h2222);
    valid_at(992, 16'h2222);
    valid_at(1008, 16'h2222);
`endif
    go_to(1023);
    checks++; if (sample_out !== 16'h0000) begin errors++; $display("FAIL coincide_pre: got %h expected 0000", sample_out); end
    checks++; if (frame_strobe !== 1'b0) begin errors++; $display("FAIL coincide_pre_strobe: got %b expected 0", frame_strobe); end
    valid_at(1024, 16'h2222);
    checks++; if (sample_out !== 16'h1111) begin errors++; $display("FAIL coincide_old: got %h expected 1111", sample_out); end
    checks++; if (frame_strobe !== 1'b1) begin errors++; $display("FAIL coincide_strobe: got %b expected 1", frame_strobe); end
    go_to(1025);
    checks++; if (frame_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b expected 0", frame_strobe); end
    go_to(2041);
    checks++; if (last_data !== exp_frame(16'h1111)) begin errors++; $display("FAIL coincide_frame_old: got %h expected %h", last_data, exp_frame(16'h1111)); end
    go_to(2048);
    checks++; if (sample_out !== 16'h2222) begin errors++; $display("FAIL coincide_new: got %h expected 2222", sample_out); end
    go_to(3065);
    checks++; if (last_data !== exp_frame(16'h2222)) begin errors++; $display("FAIL coincide_frame_new: got %h expected %h", last_data, exp_frame(16'h2222)); end
    $display("test_coincide: checks %0d", checks);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) valid_at(100 + 16 * i, 16'hFFFF);
    go_to(1024);
    checks++; if (sample_out !== 16'hFFFF) begin errors++; $display("FAIL mid_preload: got %h expected ffff", sample_out); end
    valid_at(1100, 16'h4000);
    valid_at(1116, 16'h4000);
    go_to(1355);
    checks++; if (i2s_bclk !== 1'b1) begin errors++; $display("FAIL mid_bclk_high: got %b expected 1", i2s_bclk); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL mid_async_bclk: got %b expected 0", i2s_bclk); end
    checks++; if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL mid_async_lrclk: got %b expected 0", i2s_lrclk); end
    checks++; if (i2s_data !== 1'b0) begin errors++; $display("FAIL mid_async_data: got %b expected 0", i2s_data); end
    checks++; if (frame_strobe !== 1'b0) begin errors++; $display("FAIL mid_async_strobe: got %b expected 0", frame_strobe); end
    checks++; if (sample_out !== 16'h0000) begin errors++; $display("FAIL mid_async_sample: got %h expected 0000", sample_out); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) valid_at(100 + 16 * i, 16'd8);
    go_to(1024);
    checks++; if (sample_out !== 16'd8) begin errors++; $display("FAIL mid_acc_cleared: got %h expected 0008", sample_out); end
    go_to(1017 + 1024);
    checks++; if (last_data !== exp_frame(16'd8)) begin errors++; $display("FAIL mid_frame_after: got %h expected %h", last_data, exp_frame(16'd8)); end
    $display("test_reset_mid: checks %0d", checks);
  endtask

  initial begin
    test_reset();
    test_const();
    test_last_wins();
`ifdef SID_AUDIO_AVG_EN
    test_avg();
`else
    test_direct();
`endif
    test_coincide();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
